mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory/writeback stage that consumes the ALU stage results (`regDdata`, `regBdata`, `regD`) and closes the datapath loop. It writes results back into the register file write port, which the ALU-side wiring holds disabled. It performs word loads and stores against a data memory over a req/ack handshake with wait states and a timeout. It also stalls the upstream stage while an access is outstanding.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: max cycles in MEM without `mem_ack` before abort (1..255).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream result valid this cycle.
- `in_ready`  out  1  block can accept; equals (state == IDLE), combinational from state.
- `op`  in  2  00 ALU writeback, 01 load word, 10 store word, 11 no-op (no writeback).
- `regDdata`  in  32  ALU result; memory byte address for 01/10.
- `regBdata`  in  32  store data for 10.
- `regD`  in  5  destination register.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = store, valid with `mem_req`.
- `mem_addr`  out  32  word-aligned address, held while `mem_req`.
- `mem_wdata`  out  32  store data, held while `mem_req`.
- `mem_rdata`  in  32  load data, valid when `mem_ack`.
- `mem_ack`  in  1  one-cycle completion strobe.
- `wrt_en`  out  1  register file write enable, one-cycle pulse.
- `addrD`  out  5  register file write address.
- `data_d`  out  32  register file write data.
- `exc`  out  1  one-cycle pulse: misaligned access or timeout.

## Operation
- **Transfer:** a transfer happens on an edge where `in_valid && in_ready`.
- **FSM states:**
  - IDLE: accepts input.
  - MEM: request outstanding, `in_ready`=0.
  - WB: load writeback, `in_ready`=0.
- **IDLE, op 00:**
  - Register `addrD`=`regD` and `data_d`=`regDdata`.
  - `wrt_en`=1 next cycle.
  - Stay IDLE, so back-to-back ALU ops write every cycle.
- **IDLE, op 11:** no effect.
- **IDLE, op 01/10, `regDdata[1:0]`≠0:** no memory access, no writeback, `exc`=1 next cycle, stay IDLE.
- **IDLE, op 01/10, aligned:** go to MEM.
  - Latch `mem_addr`=`regDdata`, `mem_wdata`=`regBdata`, `mem_we`=op[1], destination=`regD`.
  - `mem_req`=1 from next cycle; clear the timeout counter.
- **MEM:** counter increments each cycle without `mem_ack`.
  - `mem_ack`, load: capture `mem_rdata`, drop `mem_req`, go to WB.
  - `mem_ack`, store: drop `mem_req`, go to IDLE.
  - Counter reaches `MEM_TIMEOUT` without ack: drop `mem_req`, `exc`=1 next cycle, go to IDLE, no writeback.
  - `mem_ack` on the timeout edge: ack wins, no `exc`.
- **WB:** `wrt_en`=1, `addrD`=latched dest, `data_d`=loaded word; go to IDLE.
- **Register 0:** destination 0 never asserts `wrt_en`; the op still completes normally, including the memory access for loads.
- **Stray ack:** `mem_ack` outside MEM is ignored.
- **Reset:** all outputs 0, state IDLE, counter 0.
  - Reset mid-access drops `mem_req` at that edge.
  - No `wrt_en` or `exc` is issued for the aborted op.

## Timing
- **ALU op:** accepted at edge E0; `wrt_en` high for the cycle after E0 (latency 1).
- **Load:**
  - Accepted at E0; `mem_req` high from E0.
  - `mem_ack` sampled at Ek; `wrt_en` high for the cycle after Ek.
  - `in_ready` returns after the WB cycle.
  - Minimum occupancy 3 cycles with zero-wait ack.
- **Store:** accepted at E0; `mem_ack` at Ek; `in_ready`=1 in the cycle after Ek.
- **Handshake outputs:** `mem_addr`, `mem_wdata`, `mem_we` are stable for every cycle `mem_req`=1.
- **Pulses:** `exc` and `wrt_en` are never high in the same cycle, and each is high for exactly one cycle per event.
- **Counter:** width ≥ clog2(`MEM_TIMEOUT`+1); does not wrap.

## Test plan
- **ALU burst:** reset, then 3 consecutive ALU ops (`regD`=1,2,3, data 0xA,0xB,0xC) → `wrt_en` on 3 consecutive cycles with matching `addrD`/`data_d`; `in_ready` stays 1.
- **Load with wait states:** load addr 0x100, `regD`=5, ack after 2 wait cycles with rdata 0xDEADBEEF → `mem_req` high 3 cycles, `mem_we`=0, one `wrt_en` with `addrD`=5, `data_d`=0xDEADBEEF; `in_ready` low throughout.
- **Store and register 0:**
  - Store addr 0x40, data 0x1234, immediate ack → `mem_we`=1, no `wrt_en`, `in_ready` back after 2 cycles.
  - Load with `regD`=0 → access occurs, no `wrt_en`.
- **Misaligned and timeout:**
  - Load addr 0x102 → `mem_req` never asserted, one `exc` pulse.
  - Store with no ack → `mem_req` dropped after `MEM_TIMEOUT` cycles, one `exc`, IDLE.
- **Ack/timeout race:** ack arrives exactly on the timeout edge → completes normally, no `exc`.
- **Reset mid-access:** reset asserted in MEM mid-load → `mem_req`=0 after the reset edge; no `wrt_en`; a later stray ack is ignored.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires ALU results into the register file and runs
// word loads/stores over a req/ack memory port with a bounded wait.
module mem_wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] regDdata,
  input  logic [31:0] regBdata,
  input  logic [4:0]  regD,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wrt_en,
  output logic [4:0]  addrD,
  output logic [31:0] data_d,
  output logic        exc
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [4:0]    dest;

  assign in_ready = (state == IDLE);

  // wrt_en and exc are single-cycle strobes: cleared every edge unless re-raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      dest      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wrt_en    <= 1'b0;
      addrD     <= '0;
      data_d    <= '0;
      exc       <= 1'b0;
    end else begin
      wrt_en <= 1'b0;
      exc    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (op)
              2'b00: begin
                addrD  <= regD;
                data_d <= regDdata;
                wrt_en <= (regD != 5'd0);
              end
              2'b01, 2'b10: begin
                if (regDdata[1:0] != 2'b00) begin
                  exc <= 1'b1;
                end else begin
                  state     <= MEM;
                  mem_req   <= 1'b1;
                  mem_we    <= op[1];
                  mem_addr  <= regDdata;
                  mem_wdata <= regBdata;
                  dest      <= regD;
                  tmo_cnt   <= '0;
                end
              end
              default: ;
            endcase
          end
        end

        // An ack on the same edge the counter expires takes priority over the timeout.
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              state  <= WB;
              addrD  <= dest;
              data_d <= mem_rdata;
              wrt_en <= (dest != 5'd0);
            end
          end else if (tmo_cnt == CW'(MEM_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            exc     <= 1'b1;
            state   <= IDLE;
            tmo_cnt <= tmo_cnt + CW'(1);
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        WB: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: fixed vectors, directed memory sequences, and random
// traffic checked against a cycle-scheduled transaction model.
module tb_mem_wb_stage;

  localparam int T = 6;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] regDdata;
  logic [31:0] regBdata;
  logic [4:0]  regD;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wrt_en;
  logic [4:0]  addrD;
  logic [31:0] data_d;
  logic        exc;

  mem_wb_stage #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .regDdata(regDdata), .regBdata(regBdata), .regD(regD),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wrt_en(wrt_en), .addrD(addrD), .data_d(data_d), .exc(exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish in time");
    $fatal(1);
  end

  int checks = 0;
  int passes = 0;

  // Model state: each expected event is stamped with the cycle it must appear in.
  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  int          eq[$];
  int          cyc = 0;
  int          busy_until = 0;
  int          req_lo = 1;
  int          req_hi = 0;
  int          ack_cyc = -1;
  logic [31:0] ack_data;
  logic [31:0] exp_addr;
  logic        exp_we;
  logic [31:0] exp_wd;
  logic        st_we;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        stray_en = 1'b0;
  logic        force_stray = 1'b0;
  logic [31:0] mem[logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
  endtask

  task automatic tick();
    logic req_exp;
    logic wr_exp;
    logic ex_exp;
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, cyc > busy_until});
    req_exp = (cyc >= req_lo) && (cyc <= req_hi);
    checkOutput("mem_req", {31'd0, mem_req}, {31'd0, req_exp});
    if (req_exp) begin
      checkOutput("mem_addr", mem_addr, exp_addr);
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wd);
    end
    wr_exp = (wq.size() > 0) && (wq[0].cyc == cyc);
    checkOutput("wrt_en", {31'd0, wrt_en}, {31'd0, wr_exp});
    if (wr_exp) begin
      checkOutput("addrD", {27'd0, addrD}, {27'd0, wq[0].a});
      checkOutput("data_d", data_d, wq[0].d);
      void'(wq.pop_front());
    end
    ex_exp = (eq.size() > 0) && (eq[0] == cyc);
    checkOutput("exc", {31'd0, exc}, {31'd0, ex_exp});
    if (ex_exp) void'(eq.pop_front());
    if (cyc == ack_cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = ack_data;
      if (st_we) mem[st_addr] = st_data;
    end else if (req_exp) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end else begin
      mem_ack   = force_stray | (stray_en & ($urandom_range(0, 3) == 0));
      mem_rdata = $urandom;
    end
  endtask

  // Present one op in the current cycle and schedule everything it must cause.
  task automatic applyStimulus(input logic [1:0] o, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] b, input int w);
    int c;
    c = cyc;
    in_valid = 1'b1;
    op       = o;
    regD     = rd;
    regDdata = a;
    regBdata = b;
    if (o == 2'b00) begin
      if (rd != 5'd0) wq.push_back('{c + 1, rd, a});
    end else if (o != 2'b11) begin
      if (a[1:0] != 2'b00) begin
        eq.push_back(c + 1);
      end else begin
        req_lo   = c + 1;
        exp_addr = a;
        exp_we   = o[1];
        exp_wd   = b;
        st_we    = 1'b0;
        if (w >= T) begin
          req_hi     = c + T;
          ack_cyc    = -1;
          busy_until = c + T;
          eq.push_back(c + T + 1);
        end else begin
          req_hi  = c + 1 + w;
          ack_cyc = c + 1 + w;
          if (o == 2'b01) begin
            ack_data   = memval(a);
            busy_until = c + w + 2;
            if (rd != 5'd0) wq.push_back('{c + w + 2, rd, ack_data});
          end else begin
            st_we      = 1'b1;
            st_addr    = a;
            st_data    = b;
            busy_until = c + 1 + w;
          end
        end
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cyc <= busy_until || wq.size() > 0 || eq.size() > 0) && n < 200) begin
      in_valid = 1'b0;
      tick();
      n++;
    end
    checkOutput("drain bound", n < 200, 1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    wq.delete();
    eq.delete();
    req_lo     = 1;
    req_hi     = 0;
    ack_cyc    = -1;
    busy_until = cyc;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] base[4];
  logic [1:0]  ro;
  logic [31:0] ra;
  int          rw;
  int          gap;

  initial begin
    vecs[0] = '{2'b00, 5'd1,  32'h0000000A, 1'b1, 5'd1,  32'h0000000A, 1'b0};
    vecs[1] = '{2'b00, 5'd2,  32'h0000000B, 1'b1, 5'd2,  32'h0000000B, 1'b0};
    vecs[2] = '{2'b00, 5'd3,  32'h0000000C, 1'b1, 5'd3,  32'h0000000C, 1'b0};
    vecs[3] = '{2'b00, 5'd0,  32'h00000055, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[4] = '{2'b11, 5'd7,  32'h00000100, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[5] = '{2'b01, 5'd9,  32'h00000102, 1'b0, 5'd0,  32'h0,        1'b1};
    vecs[6] = '{2'b10, 5'd9,  32'h00000043, 1'b0, 5'd0,  32'h0,        1'b1};
    vecs[7] = '{2'b00, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
    base = '{32'h100, 32'h104, 32'h40, 32'h44};

    reset = 1'b1; in_valid = 1'b0; op = 2'b11; regD = '0;
    regDdata = '0; regBdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset mem_we", {31'd0, mem_we}, 32'h0);
    checkOutput("reset addrD", {27'd0, addrD}, 32'h0);
    checkOutput("reset data_d", data_d, 32'h0);

    // Back-to-back single-cycle ops, including the ALU burst.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].a, 32'h0, 0);
      checkOutput("tbl wrt_en", {31'd0, wrt_en}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        checkOutput("tbl addrD", {27'd0, addrD}, {27'd0, vecs[i].exp_addr});
        checkOutput("tbl data_d", data_d, vecs[i].exp_data);
      end
      checkOutput("tbl exc", {31'd0, exc}, {31'd0, vecs[i].exp_exc});
      checkOutput("tbl in_ready", {31'd0, in_ready}, 32'h1);
    end
    drain();

    mem[32'h100] = 32'hDEADBEEF;
    applyStimulus(2'b01, 5'd5, 32'h100, 32'h0, 2);
    drain();
    applyStimulus(2'b10, 5'd8, 32'h40, 32'h1234, 0);
    drain();
    applyStimulus(2'b01, 5'd0, 32'h40, 32'h0, 0);
    drain();
    applyStimulus(2'b10, 5'd8, 32'h44, 32'h9999, T + 5);
    drain();
    applyStimulus(2'b01, 5'd6, 32'h40, 32'h0, T - 1);
    drain();
    checkOutput("race keeps old store", memval(32'h44), {16'h0044, 16'hC0DE});

    applyStimulus(2'b01, 5'd7, 32'h104, 32'h0, 10);
    tick();
    tick();
    tick();
    do_reset();
    force_stray = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    force_stray = 1'b0;
    drain();

    stray_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      while (cyc <= busy_until) begin
        in_valid = 1'($urandom); op = 2'($urandom);
        regD = 5'($urandom); regDdata = $urandom;
        tick();
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'($urandom); op = 2'b11;
        tick();
      end
      ro = 2'($urandom);
      ra = base[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      if (ro == 2'b00) ra = $urandom;
      rw = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
      applyStimulus(ro, 5'($urandom), ra, $urandom, rw);
    end
    stray_en = 1'b0;
    drain();
    checkOutput("pending writes", wq.size(), 0);
    checkOutput("pending exc", eq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
